// File: rtl/ysyx_23060191_mc_sequencer.sv
// ysyx_23060191_mc_sequencer: multi-cycle instruction sequencer with bus handshakes, counters and timeout.
module ysyx_23060191_mc_sequencer #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [XLEN-1:0]  ifu_req_addr,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_inst,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_wr_rd,
  input  logic             dec_wr_csr,
  input  logic             dec_is_ebreak,
  input  logic [XLEN-1:0]  next_pc,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  output logic [XLEN-1:0]  pc,
  output logic [31:0]      inst,
  output logic             gpr_wr_en,
  output logic             csr_wr_en,
  output logic             halted,
  output logic             bus_err,
  output logic             err_is_data,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  typedef enum logic [2:0] {F_REQ, F_WAIT, EXEC, M_REQ, M_WAIT, WB, HALT, ERR} state_t;
  state_t state, state_n;
  logic [TW-1:0] tcnt;
  logic waiting, hit, expire;
  always_comb begin
    waiting = state inside {F_REQ, F_WAIT, M_REQ, M_WAIT};
    hit = (state == F_REQ && ifu_req_ready) || (state == F_WAIT && ifu_rsp_valid) ||
          (state == M_REQ && lsu_req_ready) || (state == M_WAIT && lsu_rsp_valid);
    // the awaited event beats an expiring timeout in the same cycle
    expire = waiting && !hit && tcnt == TW'(TIMEOUT - 1);
    state_n = state;
    case (state)
      F_REQ:   state_n = ifu_req_ready ? F_WAIT : F_REQ;
      F_WAIT:  state_n = ifu_rsp_valid ? EXEC : F_WAIT;
      EXEC:    state_n = dec_is_ebreak ? HALT : (dec_is_load || dec_is_store) ? M_REQ : WB;
      M_REQ:   state_n = lsu_req_ready ? M_WAIT : M_REQ;
      M_WAIT:  state_n = lsu_rsp_valid ? WB : M_WAIT;
      WB:      state_n = F_REQ;
      default: state_n = state;
    endcase
    if (expire) state_n = ERR;
  end
  assign ifu_req_valid = state == F_REQ;
  assign ifu_req_addr  = pc;
  assign lsu_req_valid = state == M_REQ;
  assign gpr_wr_en     = state == WB && dec_wr_rd;
  assign csr_wr_en     = state == WB && dec_wr_csr;
  assign halted        = state == HALT;
  assign bus_err       = state == ERR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= F_REQ;
      pc          <= RESET_PC;
      inst        <= '0;
      tcnt        <= '0;
      err_is_data <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state <= state_n;
      tcnt  <= (state_n == state && waiting) ? tcnt + TW'(1) : '0;
      if (expire) err_is_data <= state inside {M_REQ, M_WAIT};
      if (state == F_WAIT && ifu_rsp_valid) inst <= ifu_rsp_inst;
      if (state == WB) begin
        pc          <= next_pc;
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
      if (!(state inside {HALT, ERR})) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ysyx_23060191_mc_sequencer.sv
// tb_ysyx_23060191_mc_sequencer: table, random and corner-case checks of the multi-cycle sequencer.
module tb_ysyx_23060191_mc_sequencer;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic clk, rst;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_req_addr, ifu_rsp_inst;
  logic dec_is_load, dec_is_store, dec_wr_rd, dec_wr_csr, dec_is_ebreak;
  logic [31:0] next_pc, pc, inst;
  logic lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic gpr_wr_en, csr_wr_en, halted, bus_err, err_is_data;
  logic [63:0] cycle_cnt, instret_cnt;
  int checks = 0, failures = 0;
  logic [31:0] exp_pc;
  longint instret_m, cyc_m;
  bit junk_en;

  ysyx_23060191_mc_sequencer dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_wr_rd(dec_wr_rd),
    .dec_wr_csr(dec_wr_csr), .dec_is_ebreak(dec_is_ebreak), .next_pc(next_pc),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .pc(pc), .inst(inst), .gpr_wr_en(gpr_wr_en), .csr_wr_en(csr_wr_en),
    .halted(halted), .bus_err(bus_err), .err_is_data(err_is_data),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = 0;
    dec_is_load = 0; dec_is_store = 0; dec_wr_rd = 0; dec_wr_csr = 0; dec_is_ebreak = 0;
    next_pc = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    #1;
    chk("rst_pc", 64'(pc), 64'(RPC));
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    chk("rst_lsu_valid", 64'(lsu_req_valid), 0);
    @(negedge clk);
    chk("rst_inst", 64'(inst), 0);
    chk("rst_flags", {60'd0, halted, bus_err, err_is_data, gpr_wr_en | csr_wr_en}, 0);
    rst = 0;
    exp_pc = RPC; instret_m = 0; cyc_m = 0;
  endtask

  function automatic int model_cyc(int a, int b, int c, int d, bit mem, bit eb);
    return (a + 1) + b + 1 + (eb ? 0 : ((mem ? (c + 1) + d : 0) + 1));
  endfunction

  // Acts as instruction/data memory with the given delays and checks one instruction's outcome.
  task automatic do_inst(input int a, b, c, d, input bit ld, st, rd, cs, eb, err,
                         input logic [31:0] npc, input int exp_cyc, exp_lsu, input string tag);
    int fv, fh, mv, mh, cyc, gp, cp, lv;
    bit addr_ok, retire, rsp_now;
    logic [31:0] iw;
    fv = 0; fh = -1; mv = 0; mh = -1; cyc = 0; gp = 0; cp = 0; lv = 0; addr_ok = 1;
    iw = $urandom;
    dec_is_load = ld; dec_is_store = st; dec_wr_rd = rd; dec_wr_csr = cs; dec_is_ebreak = eb;
    next_pc = npc;
    while (!(halted || bus_err || (fh >= 0 && ifu_req_valid) || cyc > 2000)) begin
      gp += int'(gpr_wr_en); cp += int'(csr_wr_en); lv += int'(lsu_req_valid);
      if (ifu_req_valid && ifu_req_addr !== exp_pc) addr_ok = 0;
      ifu_req_ready = ifu_req_valid && fv >= a;
      if (ifu_req_valid) fv++;
      if (ifu_req_ready) fh = cyc;
      rsp_now = fh >= 0 && cyc == fh + b;
      ifu_rsp_valid = rsp_now || (junk_en && ifu_req_valid && $urandom_range(0, 1) == 1);
      ifu_rsp_inst = rsp_now ? iw : $urandom;
      lsu_req_ready = lsu_req_valid && mv >= c;
      if (lsu_req_valid) mv++;
      if (lsu_req_ready) mh = cyc;
      lsu_rsp_valid = (mh >= 0 && cyc == mh + d) || (junk_en && ifu_req_valid && $urandom_range(0, 1) == 1);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    ifu_req_ready = 0; ifu_rsp_valid = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
    retire = !eb && !err;
    if (retire) begin instret_m++; exp_pc = npc; end
    cyc_m += longint'(exp_cyc);
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_lsu_valid"}, 64'(lv), 64'(exp_lsu));
    chk({tag, "_gpr_pulses"}, 64'(gp), 64'(rd && retire));
    chk({tag, "_csr_pulses"}, 64'(cp), 64'(cs && retire));
    chk({tag, "_fetch_addr"}, 64'(addr_ok), 1);
    chk({tag, "_inst"}, 64'(inst), 64'(iw));
    chk({tag, "_pc"}, 64'(pc), 64'(exp_pc));
    chk({tag, "_instret"}, instret_cnt, 64'(instret_m));
    chk({tag, "_cycle"}, cycle_cnt, 64'(cyc_m));
    chk({tag, "_halted"}, 64'(halted), 64'(eb));
    chk({tag, "_bus_err"}, 64'(bus_err), 64'(err));
  endtask

  typedef struct {
    int a, b, c, d;
    bit ld, st, rd, cs;
    logic [31:0] step;
    int exp_cyc, exp_lsu;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int a, b, c, d, k, cnt;
    bit ld, st;
    logic [31:0] npc;
    rst = 1; junk_en = 0;
    clear_inputs();
    tbl[0] = '{a:0, b:1, c:0, d:0, ld:0, st:0, rd:1, cs:0, step:32'd4,     exp_cyc:4, exp_lsu:0};
    tbl[1] = '{a:0, b:1, c:3, d:1, ld:1, st:0, rd:1, cs:0, step:32'd4,     exp_cyc:9, exp_lsu:4};
    tbl[2] = '{a:1, b:2, c:0, d:2, ld:0, st:1, rd:0, cs:0, step:32'd4,     exp_cyc:9, exp_lsu:1};
    tbl[3] = '{a:2, b:3, c:0, d:0, ld:0, st:0, rd:1, cs:1, step:32'h100,   exp_cyc:8, exp_lsu:0};
    tbl[4] = '{a:0, b:1, c:0, d:0, ld:0, st:0, rd:0, cs:0, step:32'hFFFC, exp_cyc:4, exp_lsu:0};
    do_reset();
    for (int i = 0; i < 5; i++)
      do_inst(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].ld, tbl[i].st, tbl[i].rd, tbl[i].cs,
              0, 0, exp_pc + tbl[i].step, tbl[i].exp_cyc, tbl[i].exp_lsu, $sformatf("tbl%0d", i));
    junk_en = 1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 3); b = $urandom_range(1, 3);
      c = $urandom_range(0, 3); d = $urandom_range(1, 3);
      k = $urandom_range(0, 2);
      ld = k == 1; st = k == 2;
      npc = $urandom_range(0, 1) == 1 ? exp_pc + 4 : ($urandom & 32'hFFFF_FFFC);
      do_inst(a, b, c, d, ld, st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, npc,
              model_cyc(a, b, c, d, ld | st, 0), (ld | st) ? c + 1 : 0, $sformatf("rnd%0d", i));
    end
    junk_en = 0;
    do_reset();
    do_inst(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, exp_pc + 4, 4, 0, "alu_a");
    do_inst(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, exp_pc + 4, 4, 0, "alu_b");
    do_inst(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, exp_pc + 4, model_cyc(0, 1, 0, 0, 0, 1), 0, "ebreak");
    chk("ebreak_pc", 64'(pc), 64'h8000_0008);
    chk("ebreak_instret", instret_cnt, 2);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); cnt += int'(ifu_req_valid); end
    chk("halt_no_fetch", 64'(cnt), 0);
    chk("halt_cycle_frozen", cycle_cnt, 64'(cyc_m));
    chk("halt_sticky", 64'(halted), 1);
    do_reset();
    do_inst(0, 1, 0, 255, 1, 0, 1, 0, 0, 0, exp_pc + 4, model_cyc(0, 1, 0, 255, 1, 0), 1, "mwait_edge");
    do_inst(0, 1, 0, 256, 1, 0, 1, 0, 0, 1, exp_pc + 4, 259, 1, "mwait_to");
    chk("data_err_side", 64'(err_is_data), 1);
    do_reset();
    ifu_req_ready = 1;
    @(negedge clk);
    ifu_req_ready = 0;
    repeat (254) @(negedge clk);
    chk("fetch_to_early", 64'(bus_err), 0);
    @(negedge clk);
    chk("fetch_to_err", 64'(bus_err), 1);
    chk("fetch_to_side", 64'(err_is_data), 0);
    repeat (5) @(negedge clk);
    chk("fetch_to_cycle", cycle_cnt, 256);
    chk("fetch_to_noreq", 64'(ifu_req_valid), 0);
    do_reset();
    do_inst(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0000_1234, 4, 0, "pre_rst");
    ifu_req_ready = 1; dec_is_load = 1; lsu_req_ready = 1;
    @(negedge clk);
    ifu_req_ready = 0; ifu_rsp_valid = 1;
    @(negedge clk);
    ifu_rsp_valid = 0;
    @(negedge clk);
    chk("mid_mreq_valid", 64'(lsu_req_valid), 1);
    @(negedge clk);
    chk("mid_mwait_valid", 64'(lsu_req_valid), 0);
    chk("mid_mwait_cycle", cycle_cnt, 64'(cyc_m + 4));
    #2 rst = 1;
    #1;
    chk("async_pc", 64'(pc), 64'(RPC));
    chk("async_lsu_valid", 64'(lsu_req_valid), 0);
    chk("async_cycle", cycle_cnt, 0);
    chk("async_instret", instret_cnt, 0);
    @(negedge clk);
    rst = 0;
    clear_inputs();
    @(negedge clk);
    chk("post_rst_freq", 64'(ifu_req_valid), 1);
    chk("post_rst_addr", 64'(ifu_req_addr), 64'(RPC));
    chk("post_rst_cycle", cycle_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
